byte_unstriping_deskew: RTL and testbench
=========================================

Name: byte_unstriping_deskew

Overview:
Receive-side counterpart of the two-lane byte striper. Two lanes carry alternating 32-bit words: word 0 on lane 0, word 1 on lane 1, and so on. Each lane feeds a small per-lane FIFO that absorbs inter-lane skew. The block aligns on the first word of each lane, then re-interleaves lane 0 and lane 1 words into one ordered stream, with skew-limit and overflow error detection. It sits between the per-lane receive path and the link-layer data input, in the clk_2f domain.

Parameters:
WIDTH, 32, data width per lane and of data_out.
DEPTH, 4, per-lane FIFO depth in words; power of 2, minimum 2.
MAX_SKEW, 3, maximum consecutive cycles one lane may hold data while the other is empty before alignment; range 1..DEPTH-1.

Ports:
clk_2f  input  1  single clock, rising edge
reset_L  input  1  asynchronous, active-low reset
lane_0  input  WIDTH  lane 0 word (even words)
valid_0  input  1  lane_0 qualifier; writes FIFO0 on the edge
lane_1  input  WIDTH  lane 1 word (odd words)
valid_1  input  1  lane_1 qualifier; writes FIFO1 on the edge
data_out  output  WIDTH  re-ordered word
valid_out  output  1  data_out qualifier, one cycle per word
aligned  output  1  high while in RUN
skew_err  output  1  sticky; alignment skew exceeded
ovf_err  output  1  sticky; a lane FIFO overflowed

Behaviour:
- Reset (reset_L=0, asynchronous):
  - data_out=0, valid_out=0, aligned=0, skew_err=0, ovf_err=0.
  - Both FIFOs empty, skew counter=0, sel=0, state=IDLE.
  - Applies mid-stream too; all buffered words are discarded.
- FIFO write: on the edge when valid_n=1 and state!=ERR.
  - Full FIFO with no pop on the same edge: word dropped, ovf_err<=1, state<=ERR.
  - Full FIFO with a pop on the same edge: legal, no error.
- State IDLE:
  - No pops.
  - Skew counter increments on each edge where exactly one FIFO is non-empty; it clears when both are empty.
  - Both FIFOs non-empty on an edge: state<=RUN, sel<=0, counter<=0, aligned<=1.
  - Counter reaching MAX_SKEW (that many consecutive one-sided cycles): skew_err<=1, state<=ERR.
- State RUN:
  - Each edge, if FIFO[sel] is non-empty: pop its head, data_out<=head, valid_out<=1, sel<=~sel.
  - Otherwise (underrun): valid_out<=0, sel unchanged, data_out holds its last value. No error is raised; the stream resumes in order when data arrives.
- State ERR:
  - valid_out=0, aligned=0, inputs ignored, FIFO contents frozen.
  - Exit only via reset.
- Latency: a word written on edge k can appear on data_out after edge k+1 at the earliest.
  - The first word after alignment appears one edge after the IDLE->RUN edge.
- Throughput: at most one output word per cycle. Sustained aggregate input above 1 word/cycle eventually overflows, and that is the defined outcome.
- Ordering: output strictly alternates lane 0, lane 1, lane 0, ... starting with lane 0. No duplication or loss while not in ERR.
- Simultaneous events: a write and a pop on the same FIFO and edge are both performed. Error precedence on one edge: ovf_err and skew_err may both set; state goes to ERR.

Test Plan:
1. Zero skew, each lane valid every other cycle. Lane 0 carries FFFF_FFFF, DDDD_DDDD; lane 1 carries EEEE_EEEE, CCCC_CCCC, repeated 4x. Required: aligned=1, then data_out = FFFF_FFFF, EEEE_EEEE, DDDD_DDDD, CCCC_CCCC, ... 16 valid words in order, no errors.
2. Lane 1 delayed 2 cycles vs lane 0, same data as test 1. Required: aligned rises on the edge after lane 1's first write, identical output order, skew_err=0.
3. Lane 0 sends FFFF_FFFF, lane 1 silent for 4 cycles (MAX_SKEW=3). Required: skew_err=1 after the 3rd one-sided edge, aligned=0, valid_out stays 0 thereafter, even once lane 1 later sends EEEE_EEEE.
4. After alignment, lane 1 pauses 3 cycles mid-stream. Required: valid_out=0 during the gap. Resumes with the next lane 1 word, then lane 0; no duplicate or skipped word.
5. After alignment, lane 1 silent and lane 0 valid 6 consecutive cycles (DEPTH=4). Required: ovf_err=1 on the first write to the full FIFO0, state ERR, valid_out=0.
6. Assert reset_L=0 asynchronously mid-burst (between clock edges). Required: all outputs 0 immediately. After release, a fresh test-1 stream re-aligns and outputs FFFF_FFFF first.

Source files
------------

// File: rtl/byte_unstriping_deskew.sv
// Two-lane byte unstriper with deskew.
// Each lane writes a small FIFO that absorbs inter-lane skew. Once both FIFOs
// hold data, the block interleaves lane 0 and lane 1 words into one ordered
// stream, starting with lane 0.
// Ports:
//   clk_2f    - single clock, rising edge
//   reset_L   - asynchronous active-low reset
//   lane_0/1  - lane words (lane 0 carries even words, lane 1 odd words)
//   valid_0/1 - lane qualifiers; each writes its FIFO on the edge
//   data_out  - re-ordered word, held across underruns
//   valid_out - data_out qualifier, one cycle per word
//   aligned   - high while the stream is being interleaved
//   skew_err  - sticky: one lane held data too long before alignment
//   ovf_err   - sticky: a lane FIFO overflowed
module byte_unstriping_deskew #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_SKEW = 3
) (
    input  logic             clk_2f,
    input  logic             reset_L,
    input  logic [WIDTH-1:0] lane_0,
    input  logic             valid_0,
    input  logic [WIDTH-1:0] lane_1,
    input  logic             valid_1,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             aligned,
    output logic             skew_err,
    output logic             ovf_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(MAX_SKEW + 1);

    typedef enum logic [1:0] {StIdle, StRun, StErr} state_e;

    state_e           state_q, state_d;
    logic             sel_q, sel_d;
    logic [CW-1:0]    skew_cnt_q, skew_cnt_d;
    logic             skew_err_q, skew_err_d;
    logic             ovf_err_q, ovf_err_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             valid_out_q, valid_out_d;

    logic [WIDTH-1:0] din [2];
    logic [WIDTH-1:0] head_lane [2];
    logic [WIDTH-1:0] head;
    logic [1:0]       in_valid, empty, full, push, pop, ovf;
    logic             running, frozen;

    assign din[0]   = lane_0;
    assign din[1]   = lane_1;
    assign in_valid = {valid_1, valid_0};
    assign running  = (state_q == StRun);
    assign frozen   = (state_q == StErr);

    // Only the lane selected by sel may pop, and only while running.
    assign pop  = running ? {sel_q & ~empty[1], ~sel_q & ~empty[0]} : 2'b00;
    // A full FIFO still accepts a write when it pops on the same edge.
    assign push = frozen ? 2'b00 : (in_valid & (~full | pop));
    assign ovf  = frozen ? 2'b00 : (in_valid & full & ~pop);
    assign head = sel_q ? head_lane[1] : head_lane[0];

    for (genvar g = 0; g < 2; g++) begin : g_lane
        logic [WIDTH-1:0] mem_q [DEPTH];
        logic [AW-1:0]    wptr_q, rptr_q;
        logic [AW:0]      cnt_q;

        assign empty[g]     = (cnt_q == '0);
        assign full[g]      = (cnt_q == (AW + 1)'(DEPTH));
        assign head_lane[g] = mem_q[rptr_q];

        // Storage needs no reset; the pointers define what is valid.
        always_ff @(posedge clk_2f) begin
            if (push[g]) begin
                mem_q[wptr_q] <= din[g];
            end
        end

        always_ff @(posedge clk_2f or negedge reset_L) begin
            if (!reset_L) begin
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
            end else begin
                if (push[g]) wptr_q <= wptr_q + 1'b1;
                if (pop[g])  rptr_q <= rptr_q + 1'b1;
                case ({push[g], pop[g]})
                    2'b10:   cnt_q <= cnt_q + 1'b1;
                    2'b01:   cnt_q <= cnt_q - 1'b1;
                    default: cnt_q <= cnt_q;
                endcase
            end
        end
    end

    // State register.
    always_ff @(posedge clk_2f or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= StIdle;
            sel_q       <= 1'b0;
            skew_cnt_q  <= '0;
            skew_err_q  <= 1'b0;
            ovf_err_q   <= 1'b0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            skew_cnt_q  <= skew_cnt_d;
            skew_err_q  <= skew_err_d;
            ovf_err_q   <= ovf_err_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        skew_cnt_d = skew_cnt_q;
        skew_err_d = skew_err_q;
        ovf_err_d  = ovf_err_q;
        unique case (state_q)
            StIdle: begin
                if (!empty[0] && !empty[1]) begin
                    state_d    = StRun;
                    sel_d      = 1'b0;
                    skew_cnt_d = '0;
                end else if (empty[0] && empty[1]) begin
                    skew_cnt_d = '0;
                end else begin
                    skew_cnt_d = skew_cnt_q + 1'b1;
                    if (skew_cnt_d == CW'(MAX_SKEW)) begin
                        skew_err_d = 1'b1;
                        state_d    = StErr;
                    end
                end
            end
            StRun: begin
                if (|pop) sel_d = ~sel_q;
            end
            StErr: begin
            end
            default: state_d = StErr;
        endcase
        // Overflow can coincide with a skew error; both flags set.
        if (|ovf) begin
            ovf_err_d = 1'b1;
            state_d   = StErr;
        end
    end

    // Outputs.
    always_comb begin
        aligned     = (state_q == StRun);
        valid_out_d = (|pop) && (state_d != StErr);
        data_out_d  = (|pop) ? head : data_out_q;
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;
    assign skew_err  = skew_err_q;
    assign ovf_err   = ovf_err_q;

endmodule

// File: tb/tb_byte_unstriping_deskew.sv
module tb_byte_unstriping_deskew;

    logic        clk_2f = 1'b0;
    logic        reset_L;
    logic [31:0] lane_0, lane_1;
    logic        valid_0, valid_1;
    logic [31:0] data_out;
    logic        valid_out, aligned, skew_err, ovf_err;

    int          total = 0;
    int          bad = 0;
    int          out_cnt = 0;
    int          gap;
    logic [31:0] first_word;
    logic [31:0] exp0[$];
    logic [31:0] exp1[$];
    logic        msel = 1'b0;

    byte_unstriping_deskew #(
        .WIDTH(32),
        .DEPTH(4),
        .MAX_SKEW(3)
    ) dut (
        .clk_2f   (clk_2f),
        .reset_L  (reset_L),
        .lane_0   (lane_0),
        .valid_0  (valid_0),
        .lane_1   (lane_1),
        .valid_1  (valid_1),
        .data_out (data_out),
        .valid_out(valid_out),
        .aligned  (aligned),
        .skew_err (skew_err),
        .ovf_err  (ovf_err)
    );

    always #5 clk_2f = ~clk_2f;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Scoreboard: expected stream alternates lane 0, lane 1 starting at lane 0.
    always @(negedge clk_2f) begin
        if (reset_L && valid_out) begin
            if (out_cnt == 0) first_word = data_out;
            out_cnt++;
            if (!msel) begin
                if (exp0.size() == 0) check("spurious_lane0_word", 32'd1, 32'd0);
                else check("order_lane0", data_out, exp0.pop_front());
            end else begin
                if (exp1.size() == 0) check("spurious_lane1_word", 32'd1, 32'd0);
                else check("order_lane1", data_out, exp1.pop_front());
            end
            msel = ~msel;
        end
    end

    // Drive one cycle of stimulus at the falling edge; return just after the rising edge.
    task automatic cycle(input logic v0, input logic [31:0] d0,
                         input logic v1, input logic [31:0] d1);
        @(negedge clk_2f);
        valid_0 = v0;
        lane_0  = d0;
        valid_1 = v1;
        lane_1  = d1;
        if (v0) exp0.push_back(d0);
        if (v1) exp1.push_back(d1);
        @(posedge clk_2f);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic clear_sb();
        exp0.delete();
        exp1.delete();
        msel    = 1'b0;
        out_cnt = 0;
    endtask

    task automatic do_reset();
        @(negedge clk_2f);
        valid_0 = 1'b0;
        valid_1 = 1'b0;
        lane_0  = '0;
        lane_1  = '0;
        reset_L = 1'b0;
        clear_sb();
        repeat (2) @(negedge clk_2f);
        reset_L = 1'b1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_data_out"}, data_out, 32'h0);
        check({tag, "_valid_out"}, {31'b0, valid_out}, 32'd0);
        check({tag, "_aligned"}, {31'b0, aligned}, 32'd0);
        check({tag, "_skew_err"}, {31'b0, skew_err}, 32'd0);
        check({tag, "_ovf_err"}, {31'b0, ovf_err}, 32'd0);
    endtask

    // Zero-skew stream: lanes valid together every other cycle.
    task automatic t1_stream(input string tag);
        for (int r = 0; r < 8; r++) begin
            cycle(1'b1, (r % 2 == 0) ? 32'hFFFF_FFFF : 32'hDDDD_DDDD,
                  1'b1, (r % 2 == 0) ? 32'hEEEE_EEEE : 32'hCCCC_CCCC);
            if (r == 0) check({tag, "_not_yet_aligned"}, {31'b0, aligned}, 32'd0);
            cycle(1'b0, 32'h0, 1'b0, 32'h0);
            if (r == 0) check({tag, "_aligned"}, {31'b0, aligned}, 32'd1);
        end
        idle(6);
        check({tag, "_word_count"}, out_cnt, 32'd16);
        check({tag, "_lane0_drained"}, exp0.size(), 32'd0);
        check({tag, "_lane1_drained"}, exp1.size(), 32'd0);
        check({tag, "_no_errs"}, {30'b0, skew_err, ovf_err}, 32'd0);
        check({tag, "_still_aligned"}, {31'b0, aligned}, 32'd1);
    endtask

    initial begin
        valid_0 = 1'b0;
        valid_1 = 1'b0;
        lane_0  = '0;
        lane_1  = '0;
        reset_L = 1'b0;
        #12;
        check_quiet("reset");
        do_reset();

        // 1: zero skew
        t1_stream("t1");

        // 2: lane 1 lags lane 0 by two cycles
        do_reset();
        for (int i = 0; i < 18; i++) begin
            logic        v0, v1;
            logic [31:0] d0, d1;
            v0 = (i % 2 == 0) && (i <= 14);
            v1 = (i % 2 == 0) && (i >= 2) && (i <= 16);
            d0 = ((i / 2) % 2 == 0) ? 32'hFFFF_FFFF : 32'hDDDD_DDDD;
            d1 = (((i - 2) / 2) % 2 == 0) ? 32'hEEEE_EEEE : 32'hCCCC_CCCC;
            cycle(v0, v0 ? d0 : 32'h0, v1, v1 ? d1 : 32'h0);
            if (i == 2) check("t2_not_yet_aligned", {31'b0, aligned}, 32'd0);
            if (i == 3) check("t2_aligned", {31'b0, aligned}, 32'd1);
        end
        idle(6);
        check("t2_word_count", out_cnt, 32'd16);
        check("t2_lane1_drained", exp1.size(), 32'd0);
        check("t2_no_errs", {30'b0, skew_err, ovf_err}, 32'd0);

        // 3: lane 1 silent too long before alignment
        do_reset();
        cycle(1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0);
        idle(2);
        check("t3_no_skew_yet", {31'b0, skew_err}, 32'd0);
        idle(1);
        check("t3_skew_err", {31'b0, skew_err}, 32'd1);
        check("t3_not_aligned", {31'b0, aligned}, 32'd0);
        cycle(1'b0, 32'h0, 1'b1, 32'hEEEE_EEEE);
        for (int i = 0; i < 4; i++) begin
            check("t3_valid_out_low", {31'b0, valid_out}, 32'd0);
            check("t3_aligned_low", {31'b0, aligned}, 32'd0);
            idle(1);
        end
        check("t3_no_output", out_cnt, 32'd0);

        // 4: lane 1 pauses mid-stream
        do_reset();
        gap = 0;
        for (int i = 0; i < 23; i++) begin
            logic v0, v1;
            v0 = (i % 2 == 0) && (i <= 18);
            v1 = ((i % 2 == 0) && (i <= 4)) || ((i % 2 == 1) && (i >= 9) && (i <= 21));
            cycle(v0, 32'h1000_0000 + 32'(i), v1, 32'h2000_0000 + 32'(i));
            if (i >= 2 && i <= 12 && aligned && !valid_out) gap++;
        end
        idle(6);
        check("t4_gap_seen", {31'b0, gap > 0}, 32'd1);
        check("t4_word_count", out_cnt, 32'd20);
        check("t4_lane0_drained", exp0.size(), 32'd0);
        check("t4_lane1_drained", exp1.size(), 32'd0);
        check("t4_no_errs", {30'b0, skew_err, ovf_err}, 32'd0);

        // 5: FIFO0 overflow while lane 1 is silent
        do_reset();
        cycle(1'b1, 32'hA000_0000, 1'b1, 32'hB000_0000);
        for (int k = 1; k <= 6; k++) begin
            cycle(1'b1, 32'hA000_0000 + 32'(k), 1'b0, 32'h0);
            if (k == 5) check("t5_no_ovf_yet", {31'b0, ovf_err}, 32'd0);
        end
        check("t5_ovf_err", {31'b0, ovf_err}, 32'd1);
        check("t5_not_aligned", {31'b0, aligned}, 32'd0);
        check("t5_valid_out_low", {31'b0, valid_out}, 32'd0);
        cycle(1'b1, 32'hA000_0009, 1'b1, 32'hB000_0009);
        idle(4);
        check("t5_word_count", out_cnt, 32'd3);
        check("t5_still_err", {30'b0, aligned, valid_out}, 32'd0);

        // 6: asynchronous reset mid-burst, then a fresh stream
        do_reset();
        for (int r = 0; r < 3; r++) begin
            cycle(1'b1, (r % 2 == 0) ? 32'hFFFF_FFFF : 32'hDDDD_DDDD,
                  1'b1, (r % 2 == 0) ? 32'hEEEE_EEEE : 32'hCCCC_CCCC);
            cycle(1'b0, 32'h0, 1'b0, 32'h0);
        end
        #2;
        reset_L = 1'b0;
        #1;
        check_quiet("t6_async_reset");
        valid_0 = 1'b0;
        valid_1 = 1'b0;
        clear_sb();
        repeat (2) @(negedge clk_2f);
        reset_L = 1'b1;
        t1_stream("t6");
        check("t6_first_word", first_word, 32'hFFFF_FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
